// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control unit: state encoding, opcode/funct
// constants, ALU operation codes and datapath mux select codes.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        StReset   = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StExecR   = 4'd3,
        StWbR     = 4'd4,
        StExecI   = 4'd5,
        StWbI     = 4'd6,
        StAddr    = 4'd7,
        StMemRd   = 4'd8,
        StWbLw    = 4'd9,
        StMemWr   = 4'd10,
        StBranch  = 4'd11,
        StJump    = 4'd12,
        StExcCalc = 4'd13,
        StExcSave = 4'd14
    } state_e;

    typedef enum logic [2:0] {
        ClsNone,
        ClsRtype,
        ClsAddi,
        ClsLw,
        ClsSw,
        ClsBeq,
        ClsBne,
        ClsJump
    } instr_class_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;

    localparam logic [1:0] SRC_B_REG     = 2'd0;
    localparam logic [1:0] SRC_B_FOUR    = 2'd1;
    localparam logic [1:0] SRC_B_IMM     = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_EXC    = 2'd3;

    function automatic logic [2:0] r_funct_alu_op(input logic [5:0] funct);
        logic [2:0] op;
        op = ALU_ADD;
        case (funct)
            FUNCT_SUB: op = ALU_SUB;
            FUNCT_AND: op = ALU_AND;
            default:   op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: opcode/funct to instruction class, a valid flag
// and the ALU operation an R-type instruction needs.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_e instr_class,
    output logic         valid,
    output logic [2:0]   r_alu_op
);

    always_comb begin
        instr_class = ClsNone;
        valid       = 1'b0;
        r_alu_op    = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                // Only add/sub/and are implemented; any other funct is illegal.
                if (funct == FUNCT_ADD || funct == FUNCT_SUB || funct == FUNCT_AND) begin
                    instr_class = ClsRtype;
                    valid       = 1'b1;
                    r_alu_op    = r_funct_alu_op(funct);
                end
            end
            OP_ADDI: begin
                instr_class = ClsAddi;
                valid       = 1'b1;
            end
            OP_LW: begin
                instr_class = ClsLw;
                valid       = 1'b1;
            end
            OP_SW: begin
                instr_class = ClsSw;
                valid       = 1'b1;
            end
            OP_BEQ: begin
                instr_class = ClsBeq;
                valid       = 1'b1;
            end
            OP_BNE: begin
                instr_class = ClsBne;
                valid       = 1'b1;
            end
            OP_J: begin
                instr_class = ClsJump;
                valid       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU main control FSM (Moore, with a Mealy pc_write in BRANCH).
// Define EXC_EN to build the exception entry path (EXC_CALC/EXC_SAVE, epc_write, exc_cause).
module multicycle_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       pc_write,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dest,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       aluout_write,
    output logic [1:0] pc_source,
    output logic       epc_write,
    output logic       exc_cause,
    output logic [3:0] state_o
);

    localparam logic [2:0] WaitLast = 3'(MEM_WAIT);

    state_e       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    instr_class_e instr_class;
    logic         instr_valid;
    logic [2:0]   r_alu_op;

    ctrl_decode u_decode (
        .opcode      (opcode),
        .funct       (funct),
        .instr_class (instr_class),
        .valid       (instr_valid),
        .r_alu_op    (r_alu_op)
    );

`ifdef EXC_EN
    logic exc_cause_q, exc_cause_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_cause_q <= 1'b0;
        end else begin
            exc_cause_q <= exc_cause_d;
        end
    end

    assign exc_cause = exc_cause_q;
`else
    logic unused_overflow;
    assign unused_overflow = overflow;
    assign exc_cause       = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StReset;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = 3'd0;
        pc_write     = 1'b0;
        mem_write    = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        reg_dest     = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRC_B_REG;
        alu_control  = 3'b000;
        aluout_write = 1'b0;
        pc_source    = PC_SRC_ALU;
        epc_write    = 1'b0;
`ifdef EXC_EN
        exc_cause_d  = exc_cause_q;
`endif
        unique case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                alu_src_b   = SRC_B_FOUR;
                alu_control = ALU_ADD;
                if (cnt_q == WaitLast) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StDecode: begin
                // Branch target is computed speculatively for every instruction.
                alu_src_b    = SRC_B_IMM_SH2;
                alu_control  = ALU_ADD;
                aluout_write = 1'b1;
                if (!instr_valid) begin
`ifdef EXC_EN
                    state_d     = StExcCalc;
                    exc_cause_d = 1'b0;
`else
                    state_d     = StFetch;
`endif
                end else begin
                    case (instr_class)
                        ClsRtype:      state_d = StExecR;
                        ClsAddi:       state_d = StExecI;
                        ClsLw, ClsSw:  state_d = StAddr;
                        ClsBeq, ClsBne: state_d = StBranch;
                        ClsJump:       state_d = StJump;
                        default:       state_d = StFetch;
                    endcase
                end
            end
            StExecR: begin
                alu_src_a    = 1'b1;
                alu_control  = r_alu_op;
                aluout_write = 1'b1;
                state_d      = StWbR;
`ifdef EXC_EN
                if (overflow && r_alu_op != ALU_AND) begin
                    state_d     = StExcCalc;
                    exc_cause_d = 1'b1;
                end
`endif
            end
            StWbR: begin
                reg_write = 1'b1;
                reg_dest  = 1'b1;
                state_d   = StFetch;
            end
            StExecI: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRC_B_IMM;
                alu_control  = ALU_ADD;
                aluout_write = 1'b1;
                state_d      = StWbI;
`ifdef EXC_EN
                if (overflow) begin
                    state_d     = StExcCalc;
                    exc_cause_d = 1'b1;
                end
`endif
            end
            StWbI: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StAddr: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRC_B_IMM;
                alu_control  = ALU_ADD;
                aluout_write = 1'b1;
                state_d      = (instr_class == ClsSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                iord = 1'b1;
                if (cnt_q == WaitLast) begin
                    state_d = StWbLw;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StWbLw: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_source   = PC_SRC_ALUOUT;
                pc_write    = (instr_class == ClsBne) ? ~zero : zero;
                state_d     = StFetch;
            end
            StJump: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
                state_d   = StFetch;
            end
`ifdef EXC_EN
            StExcCalc: begin
                // PC already points past the faulting instruction; back it up by 4.
                alu_src_b    = SRC_B_FOUR;
                alu_control  = ALU_SUB;
                aluout_write = 1'b1;
                state_d      = StExcSave;
            end
            StExcSave: begin
                epc_write = 1'b1;
                pc_write  = 1'b1;
                pc_source = PC_SRC_EXC;
                state_d   = StFetch;
            end
`endif
            default: state_d = StReset;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: two instances (MEM_WAIT=1 and MEM_WAIT=3), one active at a
// time, checked every cycle against an instruction-level sequence model.
module tb_multicycle_ctrl_fsm;
    import cpu_ctrl_pkg::*;

`ifdef EXC_EN
    localparam bit ExcEn = 1'b1;
`else
    localparam bit ExcEn = 1'b0;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dest;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic       aluout_write;
        logic [1:0] pc_source;
        logic       epc_write;
        logic       exc_cause;
        logic [3:0] state;
    } outs_t;

    typedef enum {PF, PD, PER, PWR, PEI, PWI, PAD, PMR, PWL, PMW, PBR, PJ, PEC, PES} ph_e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_v;
    logic [5:0] opcode, funct;
    logic       zero, overflow;
    logic [1:0] pc_write, mem_write, iord, ir_write, reg_write, reg_dest, mem_to_reg;
    logic [1:0] alu_src_a, aluout_write, epc_write, exc_cause;
    logic [1:0] alu_src_b [2];
    logic [2:0] alu_control [2];
    logic [1:0] pc_source [2];
    logic [3:0] state_v [2];

    multicycle_ctrl_fsm #(.MEM_WAIT(1)) u_dut_w1 (
        .clk(clk), .reset(rst_v[0]), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .pc_write(pc_write[0]), .mem_write(mem_write[0]), .iord(iord[0]),
        .ir_write(ir_write[0]), .reg_write(reg_write[0]), .reg_dest(reg_dest[0]),
        .mem_to_reg(mem_to_reg[0]), .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]),
        .alu_control(alu_control[0]), .aluout_write(aluout_write[0]),
        .pc_source(pc_source[0]), .epc_write(epc_write[0]), .exc_cause(exc_cause[0]),
        .state_o(state_v[0])
    );

    multicycle_ctrl_fsm #(.MEM_WAIT(3)) u_dut_w3 (
        .clk(clk), .reset(rst_v[1]), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .pc_write(pc_write[1]), .mem_write(mem_write[1]), .iord(iord[1]),
        .ir_write(ir_write[1]), .reg_write(reg_write[1]), .reg_dest(reg_dest[1]),
        .mem_to_reg(mem_to_reg[1]), .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]),
        .alu_control(alu_control[1]), .aluout_write(aluout_write[1]),
        .pc_source(pc_source[1]), .epc_write(epc_write[1]), .exc_cause(exc_cause[1]),
        .state_o(state_v[1])
    );

    int errors = 0;
    int checks = 0;
    int act = 0;
    int act_wait = 1;

    // Model state
    outs_t exp_q[$], plan_q[$];
    string tag_q[$], plan_tag[$];
    bit    m_cause, m_bne, m_zero;
    logic [2:0] m_rop;

    // Monitor counters on the active DUT
    int cyc = 0, irw_cnt = 0, pcw_cnt = 0, regw_cnt = 0, epcw_cnt = 0, iord_cnt = 0;
    int irw_last = 0, irw_gap = 0, regw_last = 0;

    function automatic outs_t get_outs(input int i);
        outs_t o;
        o.pc_write     = pc_write[i];
        o.mem_write    = mem_write[i];
        o.iord         = iord[i];
        o.ir_write     = ir_write[i];
        o.reg_write    = reg_write[i];
        o.reg_dest     = reg_dest[i];
        o.mem_to_reg   = mem_to_reg[i];
        o.alu_src_a    = alu_src_a[i];
        o.alu_src_b    = alu_src_b[i];
        o.alu_control  = alu_control[i];
        o.aluout_write = aluout_write[i];
        o.pc_source    = pc_source[i];
        o.epc_write    = epc_write[i];
        o.exc_cause    = exc_cause[i];
        o.state        = state_v[i];
        return o;
    endfunction

    function automatic outs_t reset_outs();
        outs_t o;
        o = '0;
        o.state = StReset;
        return o;
    endfunction

    task automatic check_outs(input string tag, input outs_t a, input outs_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s @%0t: got %h required %h", tag, $time, a, e);
        end
    endtask

    task automatic check_val(input string tag, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s @%0t: got %0d required %0d", tag, $time, a, e);
        end
    endtask

    // Expected outputs for one cycle of a given phase of the current instruction.
    function automatic outs_t exp_outs(input ph_e p, input bit last);
        outs_t o;
        o = '0;
        o.exc_cause = ExcEn ? m_cause : 1'b0;
        case (p)
            PF: begin
                o.alu_src_b = 2'd1; o.alu_control = 3'b001; o.state = StFetch;
                o.ir_write = last; o.pc_write = last;
            end
            PD: begin
                o.alu_src_b = 2'd3; o.alu_control = 3'b001; o.aluout_write = 1'b1;
                o.state = StDecode;
            end
            PER: begin
                o.alu_src_a = 1'b1; o.alu_control = m_rop; o.aluout_write = 1'b1;
                o.state = StExecR;
            end
            PWR: begin o.reg_write = 1'b1; o.reg_dest = 1'b1; o.state = StWbR; end
            PEI, PAD: begin
                o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.alu_control = 3'b001;
                o.aluout_write = 1'b1; o.state = (p == PEI) ? StExecI : StAddr;
            end
            PWI: begin o.reg_write = 1'b1; o.state = StWbI; end
            PMR: begin o.iord = 1'b1; o.state = StMemRd; end
            PWL: begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.state = StWbLw; end
            PMW: begin o.iord = 1'b1; o.mem_write = 1'b1; o.state = StMemWr; end
            PBR: begin
                o.alu_src_a = 1'b1; o.alu_control = 3'b010; o.pc_source = 2'd1;
                o.pc_write = m_bne ? !m_zero : m_zero; o.state = StBranch;
            end
            PJ:  begin o.pc_write = 1'b1; o.pc_source = 2'd2; o.state = StJump; end
            PEC: begin
                o.alu_src_b = 2'd1; o.alu_control = 3'b010; o.aluout_write = 1'b1;
                o.state = StExcCalc;
            end
            PES: begin
                o.epc_write = 1'b1; o.pc_write = 1'b1; o.pc_source = 2'd3; o.state = StExcSave;
            end
            default: o = reset_outs();
        endcase
        return o;
    endfunction

    function automatic void plan(input ph_e p, input bit last);
        plan_q.push_back(exp_outs(p, last));
        plan_tag.push_back(p.name());
    endfunction

    function automatic void plan_exc(input bit cause);
        m_cause = cause;
        plan(PEC, 1'b0);
        plan(PES, 1'b0);
    endfunction

    // Expand one instruction into its expected cycle sequence.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input bit z, input bit ovf);
        bit r_ok;
        opcode = op; funct = fn; zero = z; overflow = ovf;
        m_zero = z;
        m_bne  = (op == 6'h05);
        m_rop  = (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b001;
        r_ok   = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24);
        plan_q.delete(); plan_tag.delete();
        for (int i = 0; i <= act_wait; i++) plan(PF, i == act_wait);
        plan(PD, 1'b0);
        if (r_ok) begin
            plan(PER, 1'b0);
            if (ExcEn && ovf && fn != 6'h24) plan_exc(1'b1);
            else plan(PWR, 1'b0);
        end else if (op == 6'h08) begin
            plan(PEI, 1'b0);
            if (ExcEn && ovf) plan_exc(1'b1);
            else plan(PWI, 1'b0);
        end else if (op == 6'h23) begin
            plan(PAD, 1'b0);
            for (int i = 0; i <= act_wait; i++) plan(PMR, 1'b0);
            plan(PWL, 1'b0);
        end else if (op == 6'h2b) begin
            plan(PAD, 1'b0);
            plan(PMW, 1'b0);
        end else if (op == 6'h04 || op == 6'h05) begin
            plan(PBR, 1'b0);
        end else if (op == 6'h02) begin
            plan(PJ, 1'b0);
        end else if (ExcEn) begin
            plan_exc(1'b0);
        end
    endtask

    // Called at posedge+1 of the instruction's first FETCH cycle; returns at the next one.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input bit z, input bit ovf);
        int n;
        build(op, fn, z, ovf);
        n = plan_q.size();
        while (plan_q.size() > 0) begin
            exp_q.push_back(plan_q.pop_front());
            tag_q.push_back(plan_tag.pop_front());
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(reset_outs());
            tag_q.push_back(tag);
            @(posedge clk);
            #1;
        end
    endtask

    // Run the first k-1 cycles of a load, then hit reset asynchronously inside cycle k.
    task automatic reset_mid(input int k);
        outs_t now;
        build(6'h23, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < k - 1; i++) begin
            exp_q.push_back(plan_q.pop_front());
            tag_q.push_back(plan_tag.pop_front());
        end
        repeat (k - 1) @(posedge clk);
        #2;
        check_val("iord in MEM_RD before reset", int'(iord[act]), 1);
        check_val("state MEM_RD before reset", int'(state_v[act]), int'(StMemRd));
        rst_v[act] = 1'b1;
        m_cause = 1'b0;
        exp_q.push_back(reset_outs());
        tag_q.push_back("reset mid MEM_RD");
        #1;
        now = get_outs(act);
        check_outs("async reset immediate", now, reset_outs());
        @(posedge clk);
        #1;
        hold(1, "reset held");
        rst_v[act] = 1'b0;
        hold(1, "RESET after release");
    endtask

    always @(negedge clk) begin
        outs_t a, e;
        string t;
        a = get_outs(act);
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_outs(t, a, e);
        end
        check_outs("idle dut in reset", get_outs(1 - act), reset_outs());
        if (a.ir_write) begin irw_gap = cyc - irw_last; irw_last = cyc; irw_cnt++; end
        if (a.pc_write) pcw_cnt++;
        if (a.reg_write) begin regw_cnt++; regw_last = cyc; end
        if (a.epc_write) epcw_cnt++;
        if (a.iord) iord_cnt++;
    end

    initial begin
        int s_ir, s_pc, s_rw, s_epc, s_iord, c0;
        rst_v = 2'b11; opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0;
        m_cause = 1'b0; m_bne = 1'b0; m_zero = 1'b0; m_rop = 3'b001;
        @(posedge clk);
        #1;
        hold(2, "in reset");
        rst_v[0] = 1'b0;
        hold(1, "RESET cycle");

        // MEM_WAIT=1 instance
        s_ir = irw_cnt; s_pc = pcw_cnt; s_rw = regw_cnt; c0 = cyc;
        issue(6'h00, 6'h20, 1'b0, 1'b0);                     // add
        check_val("add ir_write pulses", irw_cnt - s_ir, 1);
        check_val("add pc_write pulses", pcw_cnt - s_pc, 1);
        check_val("add reg_write pulses", regw_cnt - s_rw, 1);
        check_val("add reg_write cycle", regw_last - c0, 5);

        s_rw = regw_cnt; s_epc = epcw_cnt;
        issue(6'h00, 6'h22, 1'b1, 1'b1);                     // sub, overflow
        check_val("sub ovf reg_write", regw_cnt - s_rw, ExcEn ? 0 : 1);
        check_val("sub ovf epc_write", epcw_cnt - s_epc, ExcEn ? 1 : 0);
        issue(6'h00, 6'h24, 1'b0, 1'b1);                     // and ignores overflow

        s_pc = pcw_cnt; issue(6'h04, 6'h00, 1'b1, 1'b0);
        check_val("beq taken pc_write", pcw_cnt - s_pc, 2);
        s_pc = pcw_cnt; issue(6'h04, 6'h00, 1'b0, 1'b0);
        check_val("beq not taken pc_write", pcw_cnt - s_pc, 1);
        s_pc = pcw_cnt; issue(6'h05, 6'h00, 1'b0, 1'b1);
        check_val("bne taken pc_write", pcw_cnt - s_pc, 2);
        s_pc = pcw_cnt; issue(6'h05, 6'h00, 1'b1, 1'b0);
        check_val("bne not taken pc_write", pcw_cnt - s_pc, 1);

        issue(6'h02, 6'h00, 1'b1, 1'b1);                     // j
        issue(6'h2b, 6'h00, 1'b1, 1'b1);                     // sw, flags ignored
        issue(6'h08, 6'h00, 1'b0, 1'b0);                     // addi

        s_rw = regw_cnt;
        issue(6'h08, 6'h00, 1'b0, 1'b1);                     // addi, overflow
        check_val("addi ovf reg_write", regw_cnt - s_rw, ExcEn ? 0 : 1);
        check_val("exc_cause after addi ovf", int'(exc_cause[act]), ExcEn ? 1 : 0);
        issue(6'h23, 6'h00, 1'b0, 1'b1);                     // lw keeps cause
        check_val("exc_cause held", int'(exc_cause[act]), ExcEn ? 1 : 0);

        s_epc = epcw_cnt; s_pc = pcw_cnt;
        issue(6'h3f, 6'h00, 1'b0, 1'b0);                     // invalid opcode
        check_val("invalid op epc_write", epcw_cnt - s_epc, ExcEn ? 1 : 0);
        check_val("invalid op pc_write", pcw_cnt - s_pc, ExcEn ? 2 : 1);
        check_val("exc_cause after invalid op", int'(exc_cause[act]), 0);
        issue(6'h00, 6'h21, 1'b0, 1'b0);                     // unsupported funct

        reset_mid(5);
        issue(6'h00, 6'h20, 1'b0, 1'b0);

        // Switch to the MEM_WAIT=3 instance
        rst_v[0] = 1'b1;
        act = 1;
        act_wait = 3;
        m_cause = 1'b0;
        hold(1, "switch in reset");
        rst_v[1] = 1'b0;
        hold(1, "RESET cycle w3");

        s_iord = iord_cnt;
        issue(6'h23, 6'h00, 1'b1, 1'b1);                     // lw, MEM_WAIT=3
        check_val("lw w3 iord cycles", iord_cnt - s_iord, 4);
        issue(6'h00, 6'h20, 1'b0, 1'b0);
        check_val("lw w3 length", irw_gap, 11);
        s_pc = pcw_cnt; issue(6'h04, 6'h00, 1'b1, 1'b0);
        check_val("beq w3 pc_write", pcw_cnt - s_pc, 2);
        issue(6'h08, 6'h00, 1'b0, 1'b1);
        reset_mid(8);
        issue(6'h2b, 6'h00, 1'b0, 1'b0);

        check_val("model queue drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Main control unit for the multicycle CPU. A Moore state machine, with one Mealy branch output, drives every datapath control wire each cycle: PC, memory, IR, register bank, ALU source muxes, ALU operation, ALUOut and EPC. It decodes opcode/funct from the instruction register and sequences fetch, decode, execute, memory and write-back. It also sequences the exception entry path.

Parameters:
MEM_WAIT, 1, extra cycles a memory read needs before data is valid (legal range 1..7; 3-bit wait counter)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU Zero flag
overflow  in  1  ALU Overflow flag
pc_write  out  1  PC load
mem_write  out  1  memory write strobe
iord  out  1  address select: 0=PC, 1=ALUOut
ir_write  out  1  IR load
reg_write  out  1  register bank write
reg_dest  out  1  write register: 0=rt, 1=rd
mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  0=B, 1=const 4, 2=signext, 3=signext<<2
alu_control  out  3  001 add, 010 sub, 011 and
aluout_write  out  1  ALUOut load
pc_source  out  2  0=ALUResult, 1=ALUOut, 2=jump address, 3=exception vector
epc_write  out  1  EPC load
exc_cause  out  1  0=invalid opcode, 1=overflow
state_o  out  4  current state (debug)

Behaviour:
- Reset (asynchronous): go to RESET immediately, even mid-instruction. Wait counter clears.
- Every output is 0 in RESET and while reset is high. RESET lasts 1 cycle, then goes to FETCH.
- Outputs not listed for a state are 0.
- FETCH: iord=0, alu_src_a=0, alu_src_b=1, add.
  - Lasts MEM_WAIT+1 cycles.
  - In the final cycle: ir_write=1, pc_write=1, pc_source=0 (PC+4).
- DECODE: alu_src_a=0, alu_src_b=3, add, aluout_write=1 (branch target). Next state by opcode:
  - 0x00 with funct 0x20/0x22/0x24 -> EXEC_R
  - 0x08 -> EXEC_I
  - 0x23/0x2b -> ADDR
  - 0x04/0x05 -> BRANCH
  - 0x02 -> JUMP
  - anything else (including other R funct values) -> EXC_CALC with exc_cause=0
- EXEC_R: alu_src_a=1, alu_src_b=0, op chosen by funct (add/sub/and), aluout_write=1.
  - If overflow=1 on add/sub -> EXC_CALC with cause 1; otherwise -> WB_R.
- WB_R: reg_write=1, reg_dest=1, mem_to_reg=0 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2, add, aluout_write=1.
  - If overflow=1 -> EXC_CALC with cause 1; otherwise -> WB_I.
- WB_I: reg_write=1, reg_dest=0 -> FETCH.
- ADDR: alu_src_a=1, alu_src_b=2, add, aluout_write=1. lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD: iord=1, lasts MEM_WAIT+1 cycles -> WB_LW.
- WB_LW: reg_write=1, reg_dest=0, mem_to_reg=1 -> FETCH.
- MEM_WR: iord=1, mem_write=1 for exactly 1 cycle -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, sub, pc_source=1.
  - pc_write = zero for beq; pc_write = !zero for bne. This is combinational (Mealy) in this cycle.
  - -> FETCH.
- JUMP: pc_write=1, pc_source=2 -> FETCH.
- EXC_CALC: alu_src_a=0, alu_src_b=1, sub, aluout_write=1 (PC-4) -> EXC_SAVE.
- EXC_SAVE: epc_write=1, pc_write=1, pc_source=3 -> FETCH.
- exc_cause is registered and latched on entry to EXC_CALC. It holds until the next exception.
- An instruction that overflows never asserts reg_write.
- ALU flags are sampled only in EXEC_R, EXEC_I and BRANCH; they are ignored in every other state.

Optional Feature:
EXC_EN
- Defined: exception path as above.
- Undefined:
  - invalid opcodes go DECODE -> FETCH (treated as NOP);
  - overflow is ignored (WB always follows EXEC);
  - EXC_CALC/EXC_SAVE are not built;
  - epc_write and exc_cause are tied to 0.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum (4 bits);
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J);
  - funct constants;
  - ALU operation codes;
  - alu_src_b and pc_source select codes.
- One sub-module, ctrl_decode: combinational map from opcode/funct to instruction class plus a valid flag. DECODE and EXEC_R use it.

Test Plan:
- MEM_WAIT=1, add $3,$1,$2 (opcode 0, funct 0x20), no overflow -> FETCH 2 cycles, DECODE, EXEC_R, WB_R. reg_write=1 with reg_dest=1 on cycle 5; ir_write and pc_write each pulse once.
- lw (0x23) with MEM_WAIT=3 -> FETCH 4 cycles, DECODE, ADDR, MEM_RD 4 cycles with iord=1, WB_LW with mem_to_reg=1. Total 11 cycles.
- beq with zero=1 -> pc_write=1, pc_source=1 in BRANCH. beq with zero=0 -> pc_write=0. bne is the inverse.
- addi (0x08) with overflow=1 in EXEC_I -> EXC_CALC (sub, PC-4), then EXC_SAVE with epc_write=1, pc_source=3, exc_cause=1. reg_write is never 1.
- opcode 0x3F -> EXC_CALC with exc_cause=0. With EXC_EN undefined -> DECODE goes to FETCH and epc_write stays 0.
- Assert reset during MEM_RD of sw/lw -> state_o is RESET on the same edge and all outputs 0. After release: RESET for 1 cycle, then FETCH.
